// File: rtl/card_pkg.sv
// Shared card encoding for the hand datapath: 4-bit card codes and baccarat point value.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_KING  = 4'd13;

  // Ace..9 count face value; empty, ten/face cards and illegal codes count zero.
  function automatic logic [3:0] card_value(input card_t code);
    if (code >= CARD_ACE && code < CARD_TEN) begin
      return code;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/hand_datapath_if.sv
// Bundle of load strobes, generator hold and hand state shared by the datapath and its controller.
interface hand_datapath_if;

  logic                load_pcard1, load_pcard2, load_pcard3;
  logic                load_dcard1, load_dcard2, load_dcard3;
  logic                deal_hold;
  card_pkg::card_t     pcard1, pcard2, pcard3;
  card_pkg::card_t     dcard1, dcard2, dcard3;
  logic [3:0]          pscore, dscore;
  card_pkg::card_t     new_card;
  logic [2:0]          cards_dealt;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output deal_hold,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    input  pscore, dscore, new_card, cards_dealt
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  deal_hold,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    output pscore, dscore, new_card, cards_dealt
  );

endinterface

// File: rtl/dealcard.sv
// Card generator: steps Ace..King and wraps, frozen while deal_hold is high.
module dealcard
  import card_pkg::*;
(
  input  logic  slow_clock,
  input  logic  resetb,
  input  logic  deal_hold,
  output card_t new_card
);

  card_t card_q;

  // Any out-of-range code also recovers to Ace so the output never leaves 1..13.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      card_q <= CARD_ACE;
    end else if (!deal_hold) begin
      if (card_q >= CARD_KING || card_q == CARD_EMPTY) begin
        card_q <= CARD_ACE;
      end else begin
        card_q <= card_q + 4'd1;
      end
    end
  end

  assign new_card = card_q;

endmodule

// File: rtl/hand_datapath.sv
// Player/dealer card slots, dealt-card counter and combinational baccarat scores.
module hand_datapath
  import card_pkg::*;
(
  input  logic             slow_clock,
  input  logic             resetb,
  hand_datapath_if.slave   bus
);

  card_t      new_card;
  card_t      pcard1_q, pcard2_q, pcard3_q;
  card_t      dcard1_q, dcard2_q, dcard3_q;
  logic [2:0] cards_dealt_q, cards_dealt_d;
  logic [2:0] n_loads;
  logic [3:0] dealt_sum;
  logic [4:0] psum, dsum;
  logic [3:0] pscore, dscore;

  dealcard u_dealcard (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .deal_hold  (bus.deal_hold),
    .new_card   (new_card)
  );

  always_comb begin
    n_loads = 3'(bus.load_pcard1) + 3'(bus.load_pcard2) + 3'(bus.load_pcard3)
            + 3'(bus.load_dcard1) + 3'(bus.load_dcard2) + 3'(bus.load_dcard3);
    dealt_sum = {1'b0, cards_dealt_q} + {1'b0, n_loads};
    cards_dealt_d = (dealt_sum > 4'd6) ? 3'd6 : dealt_sum[2:0];
  end

  // Loads are independent: simultaneous strobes all capture the same card.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      pcard1_q      <= CARD_EMPTY;
      pcard2_q      <= CARD_EMPTY;
      pcard3_q      <= CARD_EMPTY;
      dcard1_q      <= CARD_EMPTY;
      dcard2_q      <= CARD_EMPTY;
      dcard3_q      <= CARD_EMPTY;
      cards_dealt_q <= 3'd0;
    end else begin
      if (bus.load_pcard1) pcard1_q <= new_card;
      if (bus.load_pcard2) pcard2_q <= new_card;
      if (bus.load_pcard3) pcard3_q <= new_card;
      if (bus.load_dcard1) dcard1_q <= new_card;
      if (bus.load_dcard2) dcard2_q <= new_card;
      if (bus.load_dcard3) dcard3_q <= new_card;
      cards_dealt_q <= cards_dealt_d;
    end
  end

  // Sum of three values is at most 27, so two conditional subtractions give mod 10.
  always_comb begin
    psum = 5'(card_value(pcard1_q)) + 5'(card_value(pcard2_q)) + 5'(card_value(pcard3_q));
    dsum = 5'(card_value(dcard1_q)) + 5'(card_value(dcard2_q)) + 5'(card_value(dcard3_q));
    if (psum >= 5'd20)      pscore = 4'(psum - 5'd20);
    else if (psum >= 5'd10) pscore = 4'(psum - 5'd10);
    else                    pscore = psum[3:0];
    if (dsum >= 5'd20)      dscore = 4'(dsum - 5'd20);
    else if (dsum >= 5'd10) dscore = 4'(dsum - 5'd10);
    else                    dscore = dsum[3:0];
  end

  assign bus.pcard1      = pcard1_q;
  assign bus.pcard2      = pcard2_q;
  assign bus.pcard3      = pcard3_q;
  assign bus.dcard1      = dcard1_q;
  assign bus.dcard2      = dcard2_q;
  assign bus.dcard3      = dcard3_q;
  assign bus.pscore      = pscore;
  assign bus.dscore      = dscore;
  assign bus.new_card    = new_card;
  assign bus.cards_dealt = cards_dealt_q;

endmodule

// File: tb/tb_hand_datapath.sv
// Scoreboard bench for hand_datapath: a reference model queues the expected state per edge.
module tb_hand_datapath;

  typedef struct packed {
    logic [3:0] p1, p2, p3, d1, d2, d3;
    logic [3:0] pscore, dscore, new_card;
    logic [2:0] cards_dealt;
  } exp_t;

  logic slow_clock = 1'b0;
  logic resetb;
  int   total = 0;
  int   bad   = 0;

  hand_datapath_if bus ();

  hand_datapath dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus.slave)
  );

  always #5 slow_clock = ~slow_clock;

  exp_t q[$];

  // Reference model state
  int m_gen;
  int m_p[3];
  int m_d[3];
  int m_cnt;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic int val(input int code);
    return (code >= 1 && code <= 9) ? code : 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.p1 = 4'(m_p[0]); e.p2 = 4'(m_p[1]); e.p3 = 4'(m_p[2]);
    e.d1 = 4'(m_d[0]); e.d2 = 4'(m_d[1]); e.d3 = 4'(m_d[2]);
    e.pscore = 4'((val(m_p[0]) + val(m_p[1]) + val(m_p[2])) % 10);
    e.dscore = 4'((val(m_d[0]) + val(m_d[1]) + val(m_d[2])) % 10);
    e.new_card = 4'(m_gen);
    e.cards_dealt = 3'(m_cnt);
    return e;
  endfunction

  // ld bits: 0..2 = player slots 1..3, 3..5 = dealer slots 1..3
  task automatic step(input logic rst, input logic [5:0] ld, input logic hold);
    exp_t e;
    @(negedge slow_clock);
    resetb = rst;
    {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = ld;
    bus.deal_hold = hold;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_p[i] = 0; m_d[i] = 0; end
      m_cnt = 0;
      m_gen = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld[i])   m_p[i] = m_gen;
        if (ld[i+3]) m_d[i] = m_gen;
      end
      m_cnt = m_cnt + $countones(ld);
      if (m_cnt > 6) m_cnt = 6;
      if (!hold) m_gen = (m_gen == 13) ? 1 : m_gen + 1;
    end
    q.push_back(snapshot());
    @(posedge slow_clock);
    #1;
    compare();
  endtask

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    check("pcard1", int'(bus.pcard1), int'(e.p1));
    check("pcard2", int'(bus.pcard2), int'(e.p2));
    check("pcard3", int'(bus.pcard3), int'(e.p3));
    check("dcard1", int'(bus.dcard1), int'(e.d1));
    check("dcard2", int'(bus.dcard2), int'(e.d2));
    check("dcard3", int'(bus.dcard3), int'(e.d3));
    check("pscore", int'(bus.pscore), int'(e.pscore));
    check("dscore", int'(bus.dscore), int'(e.dscore));
    check("new_card", int'(bus.new_card), int'(e.new_card));
    check("cards_dealt", int'(bus.cards_dealt), int'(e.cards_dealt));
  endtask

  // Advance the generator (bounded) until it presents the wanted card.
  task automatic seek(input int card);
    for (int i = 0; i < 14 && m_gen != card; i++) step(1'b0, 6'b0, 1'b0);
    check("seek", int'(bus.new_card), card);
  endtask

  task automatic load_card(input int card, input logic [5:0] ld);
    seek(card);
    step(1'b0, ld, 1'b1);
  endtask

  initial begin
    resetb = 1'b1;
    bus.deal_hold = 1'b0;
    {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = 6'b0;
    m_gen = 1; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin m_p[i] = 0; m_d[i] = 0; end

    // Reset for two edges, with loads asserted to show they are ignored
    step(1'b1, 6'b111111, 1'b1);
    step(1'b1, 6'b0, 1'b0);
    check("rst_new_card", int'(bus.new_card), 1);
    check("rst_pscore", int'(bus.pscore), 0);
    check("rst_cards_dealt", int'(bus.cards_dealt), 0);

    // Wrap after 13 edges, then hold for 5
    for (int i = 0; i < 13; i++) step(1'b0, 6'b0, 1'b0);
    check("wrap_new_card", int'(bus.new_card), 1);
    step(1'b0, 6'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 6'b0, 1'b1);
    check("hold_new_card", int'(bus.new_card), 2);

    // Deal 7 then King to the player
    load_card(7, 6'b000001);
    load_card(13, 6'b000010);
    check("deal_pscore", int'(bus.pscore), 7);

    // Mod-10 scoring
    load_card(9, 6'b000001);
    load_card(8, 6'b000010);
    load_card(6, 6'b000100);
    check("mod10_pscore", int'(bus.pscore), 3);
    load_card(13, 6'b001000);
    load_card(12, 6'b010000);
    load_card(11, 6'b100000);
    check("mod10_dscore", int'(bus.dscore), 0);
    check("sat_after_8", int'(bus.cards_dealt), 6);

    // Simultaneous capture and counter saturation from a fresh hand
    step(1'b1, 6'b0, 1'b0);
    load_card(5, 6'b100100);
    check("simul_pcard3", int'(bus.pcard3), 5);
    check("simul_dcard3", int'(bus.dcard3), 5);
    check("simul_cards_dealt", int'(bus.cards_dealt), 2);
    for (int i = 0; i < 6; i++) step(1'b0, 6'(1 << (i % 6)), 1'b0);
    check("sat_cards_dealt", int'(bus.cards_dealt), 6);

    // Mid-hand reset with a coincident dealer load
    step(1'b1, 6'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 6'(1 << i), 1'b0);
    step(1'b1, 6'b001000, 1'b0);
    check("midrst_dcard1", int'(bus.dcard1), 0);
    check("midrst_cards_dealt", int'(bus.cards_dealt), 0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0), 6'($urandom_range(0, 63) & $urandom_range(0, 63)),
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
